// File: rtl/tmds_period_ctrl.sv
// Raster timing and TMDS period sequencing (control / preamble / guard / video)
// for three video-only encoder channels, with symbols aligned to encoder q_out.
module tmds_period_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clock_me,
  input  logic       rst,
  input  logic       run,
  output logic       pix_req,
  output logic       encode_en,
  output logic       enc_rst_n,
  output logic       sym_sel,
  output logic [9:0] ch0_ctrl,
  output logic [9:0] ch1_ctrl,
  output logic [9:0] ch2_ctrl,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] PRE_FIRST = HW'(H_TOTAL - 10);
  localparam logic [HW-1:0] PRE_LAST  = HW'(H_TOTAL - 3);
  localparam logic [HW-1:0] GRD_FIRST = HW'(H_TOTAL - 2);

  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_M1  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [9:0] TOK_00    = 10'b1101010100;
  localparam logic [9:0] TOK_01    = 10'b0010101011;
  localparam logic [9:0] GUARD_CH0 = 10'b1011001100;
  localparam logic [9:0] GUARD_CH1 = 10'b0100110011;
  localparam logic [9:0] GUARD_CH2 = 10'b1011001100;

  typedef enum logic [1:0] {
    ST_CTRL     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_GUARD    = 2'd2,
    ST_VIDEO    = 2'd3
  } state_t;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = 10'b1101010100;
      2'b01:   tok = 10'b0010101011;
      2'b10:   tok = 10'b0101010100;
      2'b11:   tok = 10'b1010101011;
      default: tok = 10'b1101010100;
    endcase
    return tok;
  endfunction

  logic [HW-1:0] hcnt_r;
  logic [VW-1:0] vcnt_r;
  state_t        state_r;
  state_t        dec_state_s;
  logic          next_line_active_s;
  logic          hs_raw_s;
  logic          vs_raw_s;
  logic          origin_s;
  logic          hs1_r;
  logic          vs1_r;

  // Raster position decode; counters describe the position emitted on the next edge
  always_comb begin
    next_line_active_s = (vcnt_r < V_ACT_M1) || (vcnt_r == V_LAST);
    hs_raw_s = (hcnt_r >= HS_FIRST) && (hcnt_r <= HS_LAST);
    vs_raw_s = (vcnt_r >= VS_FIRST) && (vcnt_r <= VS_LAST);
    origin_s = (hcnt_r == {HW{1'b0}}) && (vcnt_r == {VW{1'b0}});
    if (!run) begin
      dec_state_s = ST_CTRL;
    end else if ((hcnt_r < H_ACT) && (vcnt_r < V_ACT)) begin
      dec_state_s = ST_VIDEO;
    end else if (next_line_active_s && (hcnt_r >= PRE_FIRST) && (hcnt_r <= PRE_LAST)) begin
      dec_state_s = ST_PREAMBLE;
    end else if (next_line_active_s && (hcnt_r >= GRD_FIRST)) begin
      dec_state_s = ST_GUARD;
    end else begin
      dec_state_s = ST_CTRL;
    end
  end

  // Horizontal/vertical raster counters; run low parks them at the origin
  always_ff @(posedge clock_me or posedge rst) begin
    if (rst) begin
      hcnt_r <= {HW{1'b0}};
      vcnt_r <= {VW{1'b0}};
    end else if (!run) begin
      hcnt_r <= {HW{1'b0}};
      vcnt_r <= {VW{1'b0}};
    end else if (hcnt_r == H_LAST) begin
      hcnt_r <= {HW{1'b0}};
      if (vcnt_r == V_LAST) begin
        vcnt_r <= {VW{1'b0}};
      end else begin
        vcnt_r <= vcnt_r + {{(VW-1){1'b0}}, 1'b1};
      end
    end else begin
      hcnt_r <= hcnt_r + {{(HW-1){1'b0}}, 1'b1};
    end
  end

  // Period FSM with encoder-side controls registered alongside the state
  always_ff @(posedge clock_me or posedge rst) begin
    if (rst) begin
      state_r     <= ST_CTRL;
      pix_req     <= 1'b0;
      encode_en   <= 1'b0;
      enc_rst_n   <= 1'b0;
      frame_start <= 1'b0;
      hs1_r       <= 1'b0;
      vs1_r       <= 1'b0;
    end else begin
      state_r     <= dec_state_s;
      pix_req     <= (dec_state_s == ST_VIDEO);
      encode_en   <= (dec_state_s == ST_VIDEO);
      enc_rst_n   <= (dec_state_s == ST_VIDEO);
      frame_start <= run && origin_s;
      hs1_r       <= run && hs_raw_s;
      vs1_r       <= run && vs_raw_s;
    end
  end

  // Second stage lines the mux controls up with the encoder's one-cycle latency
  always_ff @(posedge clock_me or posedge rst) begin
    if (rst) begin
      sym_sel  <= 1'b0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
      ch0_ctrl <= TOK_00;
      ch1_ctrl <= TOK_00;
      ch2_ctrl <= TOK_00;
    end else begin
      sym_sel <= (state_r == ST_VIDEO);
      hsync   <= hs1_r ? SYNC_POL : ~SYNC_POL;
      vsync   <= vs1_r ? SYNC_POL : ~SYNC_POL;
      case (state_r)
        ST_CTRL: begin
          ch0_ctrl <= ctrl_token({vs1_r, hs1_r});
          ch1_ctrl <= TOK_00;
          ch2_ctrl <= TOK_00;
        end
        ST_PREAMBLE: begin
          ch0_ctrl <= ctrl_token({vs1_r, hs1_r});
          ch1_ctrl <= TOK_01;
          ch2_ctrl <= TOK_00;
        end
        ST_GUARD: begin
          ch0_ctrl <= GUARD_CH0;
          ch1_ctrl <= GUARD_CH1;
          ch2_ctrl <= GUARD_CH2;
        end
        ST_VIDEO: begin
          ch0_ctrl <= ch0_ctrl;
          ch1_ctrl <= ch1_ctrl;
          ch2_ctrl <= ch2_ctrl;
        end
        default: begin
          ch0_ctrl <= TOK_00;
          ch1_ctrl <= TOK_00;
          ch2_ctrl <= TOK_00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_period_ctrl.sv
// Directed bench for tmds_period_ctrl on a tiny 20x5 raster with active-high syncs.
module tb_tmds_period_ctrl;

  logic       clk;
  logic       rst;
  logic       run;
  logic       pix_req;
  logic       encode_en;
  logic       enc_rst_n;
  logic       sym_sel;
  logic [9:0] ch0_ctrl;
  logic [9:0] ch1_ctrl;
  logic [9:0] ch2_ctrl;
  logic       hsync;
  logic       vsync;
  logic       frame_start;

  int pass_cnt;
  int total_cnt;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] G0  = 10'b1011001100;
  localparam logic [9:0] G1  = 10'b0100110011;
  localparam logic [9:0] G2  = 10'b1011001100;

  tmds_period_ctrl #(
    .H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(12),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut (
    .clock_me(clk),
    .rst(rst),
    .run(run),
    .pix_req(pix_req),
    .encode_en(encode_en),
    .enc_rst_n(enc_rst_n),
    .sym_sel(sym_sel),
    .ch0_ctrl(ch0_ctrl),
    .ch1_ctrl(ch1_ctrl),
    .ch2_ctrl(ch2_ctrl),
    .hsync(hsync),
    .vsync(vsync),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    logic [15:0] exp;
    got = {pix_req, encode_en, enc_rst_n, sym_sel, frame_start, hsync, vsync, 9'd0};
    exp = 16'd0;
    total_cnt++;
    if (got !== exp) $display("FAIL reset_flags got %b exp %b", got, exp);
    else pass_cnt++;
    total_cnt++;
    if ({ch0_ctrl, ch1_ctrl, ch2_ctrl} !== {T00, T00, T00})
      $display("FAIL reset_ctrl got %b %b %b exp %b", ch0_ctrl, ch1_ctrl, ch2_ctrl, T00);
    else pass_cnt++;
  endtask

  // One full frame plus the first cycle of the next; k indexes the stage-1 position
  task automatic test_frame();
    int fs_count;
    fs_count = 0;
    for (int k = 0; k <= 100; k++) begin
      int h;
      int v;
      int ph;
      int pv;
      logic e_vid;
      logic e_sym;
      logic e_hs;
      logic e_vs;
      step();
      h = k % 20;
      v = (k / 20) % 5;
      ph = (k + 19) % 20;
      pv = ((k + 99) / 20) % 5;
      e_vid = (v < 2) && (h < 4);
      e_sym = (k >= 1) && (pv < 2) && (ph < 4);
      e_hs  = (k >= 1) && (ph == 6 || ph == 7);
      e_vs  = (k >= 1) && (pv == 3);
      if (frame_start === 1'b1) fs_count++;
      total_cnt++;
      if ({pix_req, encode_en, enc_rst_n} !== {e_vid, e_vid, e_vid})
        $display("FAIL video_ctl k=%0d got %b exp %b", k, {pix_req, encode_en, enc_rst_n}, {e_vid, e_vid, e_vid});
      else pass_cnt++;
      total_cnt++;
      if (sym_sel !== e_sym) $display("FAIL sym_sel k=%0d got %b exp %b", k, sym_sel, e_sym);
      else pass_cnt++;
      total_cnt++;
      if ({hsync, vsync} !== {e_hs, e_vs})
        $display("FAIL syncs k=%0d got %b exp %b", k, {hsync, vsync}, {e_hs, e_vs});
      else pass_cnt++;
      total_cnt++;
      if (frame_start !== (k == 0 || k == 100))
        $display("FAIL frame_start k=%0d got %b", k, frame_start);
      else pass_cnt++;
      if ((k >= 11 && k <= 18) || (k >= 91 && k <= 98)) begin
        total_cnt++;
        if ({ch0_ctrl, ch1_ctrl, ch2_ctrl} !== {T00, T01, T00})
          $display("FAIL preamble k=%0d got %b %b %b", k, ch0_ctrl, ch1_ctrl, ch2_ctrl);
        else pass_cnt++;
      end
      if (k == 19 || k == 20 || k == 99 || k == 100) begin
        total_cnt++;
        if ({ch0_ctrl, ch1_ctrl, ch2_ctrl} !== {G0, G1, G2})
          $display("FAIL guard k=%0d got %b %b %b", k, ch0_ctrl, ch1_ctrl, ch2_ctrl);
        else pass_cnt++;
      end
      if (k >= 21 && k <= 24) begin
        total_cnt++;
        if ({ch0_ctrl, ch1_ctrl} !== {G0, G1})
          $display("FAIL video_hold k=%0d got %b %b exp %b %b", k, ch0_ctrl, ch1_ctrl, G0, G1);
        else pass_cnt++;
      end
      if (k >= 31 && k <= 40) begin
        total_cnt++;
        if ({ch0_ctrl, ch1_ctrl, ch2_ctrl} !== {T00, T00, T00})
          $display("FAIL last_line_ctrl k=%0d got %b %b %b", k, ch0_ctrl, ch1_ctrl, ch2_ctrl);
        else pass_cnt++;
      end
      if (k == 61 || k == 69 || k == 80) begin
        total_cnt++;
        if ({ch0_ctrl, ch1_ctrl} !== {T10, T00})
          $display("FAIL vsync_tok k=%0d got %b %b exp %b %b", k, ch0_ctrl, ch1_ctrl, T10, T00);
        else pass_cnt++;
      end
      if (k == 67 || k == 68) begin
        total_cnt++;
        if (ch0_ctrl !== T11) $display("FAIL vhsync_tok k=%0d got %b exp %b", k, ch0_ctrl, T11);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (fs_count != 2) $display("FAIL frame_period got %0d pulses exp 2", fs_count);
    else pass_cnt++;
  endtask

  task automatic test_reset_midline();
    step();
    step();
    total_cnt++;
    if (pix_req !== 1'b1) $display("FAIL pre_reset_video got %b exp 1", pix_req);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    test_reset();
    step();
    rst = 1'b0;
    step();
    total_cnt++;
    if ({frame_start, pix_req, sym_sel} !== 3'b110)
      $display("FAIL restart_origin got %b exp 110", {frame_start, pix_req, sym_sel});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({frame_start, pix_req, sym_sel} !== 3'b011)
      $display("FAIL restart_second got %b exp 011", {frame_start, pix_req, sym_sel});
    else pass_cnt++;
  endtask

  task automatic test_run_drop();
    logic [3:0] seen;
    run = 1'b0;
    step();
    total_cnt++;
    if ({encode_en, pix_req, enc_rst_n, sym_sel} !== 4'b0001)
      $display("FAIL run_drop got %b exp 0001", {encode_en, pix_req, enc_rst_n, sym_sel});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({sym_sel, ch0_ctrl} !== {1'b0, T00})
      $display("FAIL run_drop_late got %b %b exp 0 %b", sym_sel, ch0_ctrl, T00);
    else pass_cnt++;
    run = 1'b1;
    step();
    total_cnt++;
    if ({frame_start, pix_req} !== 2'b11)
      $display("FAIL run_resume got %b exp 11", {frame_start, pix_req});
    else pass_cnt++;
    seen = 4'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen[3-i] = pix_req;
    end
    total_cnt++;
    if (seen !== 4'b1110) $display("FAIL run_full_line got %b exp 1110", seen);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b1;
    run = 1'b1;
    step();
    step();
    test_reset();
    rst = 1'b0;
    test_frame();
    test_reset_midline();
    test_run_drop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tmds_period_ctrl.md
Name: tmds_period_ctrl

Overview:
- Sequences the three per-channel TMDS encoders (blue = ch0, green = ch1, red = ch2) for a DVI/HDMI video-only link.
- Generates the raster timing and the encoder `encode_en` and `rst_n` controls.
- Produces the control-period, preamble and video-guard-band 10-bit symbols that the downstream output mux selects in place of encoder `q_out`.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch; must be >= 10
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- clock_me  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- run  in  1  timing enable; low holds the raster at origin
- pix_req  out  1  pixel data must be presented to the encoders this cycle
- encode_en  out  1  drives every encoder's encode_en
- enc_rst_n  out  1  drives every encoder's rst_n; low clears encoder disparity
- sym_sel  out  1  1 = mux selects encoder q_out, 0 = selects chN_ctrl
- ch0_ctrl  out  10  ch0 substitute symbol
- ch1_ctrl  out  10  ch1 substitute symbol
- ch2_ctrl  out  10  ch2 substitute symbol
- hsync  out  1  horizontal sync at SYNC_POL
- vsync  out  1  vertical sync at SYNC_POL
- frame_start  out  1  one-cycle pulse at hcnt=0, vcnt=0

Behaviour:
- Raster counters:
  - H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
  - hcnt runs 0..H_TOTAL-1 and wraps to 0, then vcnt increments; vcnt wraps 0 after V_TOTAL-1.
  - Counters advance only when run=1; run=0 forces hcnt=vcnt=0 and state CTRL on the next edge.
- hsync is active for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync is active for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); it changes at hcnt=0.
- FSM states: CTRL, PREAMBLE, GUARD, VIDEO. State is registered and decoded from the counter values.
  - VIDEO: hcnt < H_ACTIVE and vcnt < V_ACTIVE.
  - PREAMBLE: hcnt in [H_TOTAL-10, H_TOTAL-3] and the next line is active. Next line is active when vcnt+1 < V_ACTIVE, or vcnt = V_TOTAL-1.
  - GUARD: hcnt in {H_TOTAL-2, H_TOTAL-1} under the same next-line condition.
  - CTRL: everything else.
  - Transitions: CTRL->PREAMBLE->GUARD->VIDEO->CTRL. Lines with no following active line stay in CTRL.
- Cycle t (state VIDEO): pix_req=1 and encode_en=1. The encoder q_out is valid at t+1.
- Alignment: sym_sel, chN_ctrl, hsync, vsync are delayed one stage so they align with encoder q_out. Thus sym_sel=1 exactly at the cycles following each VIDEO cycle.
- enc_rst_n is 0 during CTRL, PREAMBLE and GUARD cycles and 1 during VIDEO. Encoder disparity therefore restarts at 0 on every line.
- Control tokens, {C1,C0}:
  - 00 = 1101010100
  - 01 = 0010101011
  - 10 = 0101010100
  - 11 = 1010101011
- CTRL symbols:
  - ch0 carries {C1,C0} = {vsync_raw, hsync_raw}, using the raw (unpolarised) active-high sync.
  - ch1 and ch2 carry 00.
- PREAMBLE symbols (video preamble, CTL0=1, CTL1..3=0):
  - ch0 carries the sync token as in CTRL.
  - ch1 carries 01.
  - ch2 carries 00.
- GUARD symbols:
  - ch0 = 1011001100
  - ch1 = 0100110011
  - ch2 = 1011001100
- During VIDEO the chN_ctrl value is don't-care, but it shall hold the previous value.
- frame_start is registered and asserted at the cycle t for hcnt=0, vcnt=0.
- Reset (asynchronous, any time including mid-line):
  - Counters 0, state CTRL.
  - pix_req=0, encode_en=0, enc_rst_n=0, sym_sel=0, frame_start=0.
  - chN_ctrl = 1101010100.
  - hsync and vsync at the inactive level (~SYNC_POL).
  - First outputs after reset deassertion correspond to hcnt=0, vcnt=0.
- run dropping mid-VIDEO: encode_en and pix_req go 0 on the next edge; sym_sel follows one cycle later; no partial line resumes.

Test Plan:
- Bench parameters: H_ACTIVE=4, H_FP=2, H_SYNC=2, H_BP=12 (H_TOTAL=20); V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=5); SYNC_POL=1.
- Release rst with run=1 -> frame_start pulses once; pix_req=encode_en=1 for hcnt 0-3; sym_sel=1 one cycle later for 4 cycles; enc_rst_n=0 for hcnt 4-19.
- Line 0 blanking -> ch1_ctrl=0010101011 at the delayed slots for hcnt 10-17; all channels show the guard symbols for hcnt 18-19; ch0 guard = 1011001100.
- Line 1 (last active), hcnt 10-19 -> CTRL tokens only, no preamble/guard; vcnt 3 -> vsync=1 and ch0_ctrl=0101010100 outside hsync, 1010101011 during hcnt 6-7.
- vcnt=4 (final line) -> preamble and guard are issued, then the next frame's VIDEO line starts with frame_start=1; the frame period is 100 clocks.
- Assert rst at hcnt=2 of an active line -> all outputs take reset values immediately; after release the raster restarts at 0,0.
- Drop run at hcnt=1 -> encode_en=0 next cycle; counters at 0,0; re-raise run -> full line from hcnt 0.
